// File: rtl/filt_pkg.sv
// Shared definitions for the filter back-end: sample widths, trigger edge codes
// and the capture FSM state encoding.
package filt_pkg;

    localparam int XADC_DATA_SIZE        = 16;
    localparam int DEFAULT_DATA_SIZE     = XADC_DATA_SIZE;
    localparam int DEFAULT_BUF_ADDR_SIZE = 10;

    localparam logic TRIG_RISING  = 1'b0;
    localparam logic TRIG_FALLING = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_WAIT = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } capt_state_t;

endpackage

// File: rtl/capt_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// Only the read register is reset; the array itself maps onto block RAM.
module capt_ram import filt_pkg::*; #(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int ADDR_SIZE = DEFAULT_BUF_ADDR_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [ADDR_SIZE-1:0] i_waddr,
    input  logic [DATA_SIZE-1:0] i_wdata,
    input  logic [ADDR_SIZE-1:0] i_raddr,
    output logic [DATA_SIZE-1:0] o_rdata
);

    logic [DATA_SIZE-1:0] r_mem [0:2**ADDR_SIZE-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/filt_trig_capture.sv
// Triggered circular capture of filter results with a programmable pre-trigger
// window; the frozen buffer is read back with logical address 0 = oldest sample.
module filt_trig_capture import filt_pkg::*; #(
    parameter int DATA_SIZE     = DEFAULT_DATA_SIZE,
    parameter int BUF_ADDR_SIZE = DEFAULT_BUF_ADDR_SIZE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     force_trig,
    input  logic                     trig_edge,
    input  logic [DATA_SIZE-1:0]     trig_level,
    input  logic [BUF_ADDR_SIZE-1:0] pretrig_len,
    input  logic [DATA_SIZE-1:0]     filt_result,
    input  logic                     filt_done,
    input  logic [BUF_ADDR_SIZE-1:0] rd_addr,
    output logic [DATA_SIZE-1:0]     rd_data,
    output logic [BUF_ADDR_SIZE-1:0] trig_addr,
    output logic                     busy,
    output logic                     capt_done
);

    capt_state_t r_state, w_state_d;

    logic                     r_filt_done_q;
    logic [BUF_ADDR_SIZE-1:0] r_wr_ptr, r_cnt, r_pret, r_start_addr, r_trig_addr;
    logic [DATA_SIZE-1:0]     r_prev;
    logic                     r_prev_valid, r_force;

    logic                     w_sample_en, w_capturing, w_wr_en, w_trig_cond, w_trig_hit;
    logic [BUF_ADDR_SIZE-1:0] w_cnt_inc, w_cnt_dec, w_post_cnt, w_rd_phys;

    assign w_sample_en = filt_done & ~r_filt_done_q;
    assign w_capturing = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
    // arm wins over a coincident sample, which is dropped
    assign w_wr_en     = w_sample_en & ~arm & w_capturing;
    assign w_trig_hit  = w_wr_en && (r_state == ST_WAIT) && (r_force || w_trig_cond);
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_cnt_dec   = r_cnt - 1'b1;
    assign w_post_cnt  = {BUF_ADDR_SIZE{1'b1}} - r_pret;
    assign w_rd_phys   = r_start_addr + rd_addr;

    always_comb begin
        w_trig_cond = 1'b0;
        if (r_prev_valid) begin
            if (trig_edge == TRIG_RISING) begin
                w_trig_cond = (r_prev < trig_level) && (filt_result >= trig_level);
            end else begin
                w_trig_cond = (r_prev > trig_level) && (filt_result <= trig_level);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        if (arm) begin
            w_state_d = (pretrig_len == '0) ? ST_WAIT : ST_PRE;
        end else if (w_wr_en) begin
            case (r_state)
                ST_PRE:  if (w_cnt_inc == r_pret) w_state_d = ST_WAIT;
                ST_WAIT: if (w_trig_hit) w_state_d = (w_post_cnt == '0) ? ST_DONE : ST_POST;
                ST_POST: if (w_cnt_dec == '0) w_state_d = ST_DONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_filt_done_q <= 1'b0;
            r_wr_ptr      <= '0;
            r_cnt         <= '0;
            r_pret        <= '0;
            r_start_addr  <= '0;
            r_trig_addr   <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_force       <= 1'b0;
        end else begin
            r_filt_done_q <= filt_done;
            if (arm) begin
                r_pret       <= pretrig_len;
                r_wr_ptr     <= '0;
                r_cnt        <= '0;
                r_prev_valid <= 1'b0;
                r_force      <= 1'b0;
            end else begin
                if (w_wr_en) begin
                    r_wr_ptr     <= r_wr_ptr + 1'b1;
                    r_prev       <= filt_result;
                    r_prev_valid <= 1'b1;
                end
                if (w_wr_en && (r_state == ST_PRE)) begin
                    r_cnt <= w_cnt_inc;
                end
                if (w_wr_en && (r_state == ST_POST)) begin
                    r_cnt <= w_cnt_dec;
                end
                // a trigger consumes any pending force request
                if (w_trig_hit) begin
                    r_trig_addr  <= r_wr_ptr;
                    r_start_addr <= r_wr_ptr - r_pret;
                    r_cnt        <= w_post_cnt;
                    r_force      <= 1'b0;
                end else if ((r_state == ST_WAIT) && force_trig) begin
                    r_force <= 1'b1;
                end
            end
        end
    end

    capt_ram #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (BUF_ADDR_SIZE)
    ) u_capt_ram (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (filt_result),
        .i_raddr (w_rd_phys),
        .o_rdata (rd_data)
    );

    assign trig_addr = r_trig_addr;
    assign busy      = w_capturing;
    assign capt_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_filt_trig_capture.sv
// Bench for filt_trig_capture: sample-index reference model plus directed and random captures.
module tb_filt_trig_capture;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          force_trig = 1'b0;
    logic          trig_edge = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic [AW-1:0] pretrig_len = '0;
    logic [DW-1:0] filt_result = '0;
    logic          filt_done = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] trig_addr;
    logic          busy, capt_done;

    always #5 clk = ~clk;

    filt_trig_capture #(.DATA_SIZE(DW), .BUF_ADDR_SIZE(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .force_trig  (force_trig),
        .trig_edge   (trig_edge),
        .trig_level  (trig_level),
        .pretrig_len (pretrig_len),
        .filt_result (filt_result),
        .filt_done   (filt_done),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .trig_addr   (trig_addr),
        .busy        (busy),
        .capt_done   (capt_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: samples since the last arm are numbered k = 0,1,...; sample k lands at k mod DEPTH.
    bit            m_armed = 0;
    bit            m_force = 0;
    bit            m_fd_q = 0;
    bit            m_done_before = 0;
    int            m_pret = 0;
    int            m_ns = 0;
    int            m_trig_idx = -1;
    int            m_trig_addr = 0;
    int            m_rd_at_edge = 0;
    logic [DW-1:0] m_samp[$];

    function automatic bit m_done();
        return m_armed && (m_trig_idx >= 0) && (m_ns == m_trig_idx + DEPTH - m_pret);
    endfunction

    function automatic bit crosses(input logic [DW-1:0] p, input logic [DW-1:0] c);
        if (trig_edge == 1'b0) return (p < trig_level) && (c >= trig_level);
        return (p > trig_level) && (c <= trig_level);
    endfunction

    always @(posedge clk) begin
        bit se, waiting, hit;
        int k;
        m_done_before = m_done();
        m_rd_at_edge  = int'(rd_addr);
        if (rst) begin
            m_armed = 0; m_fd_q = 0; m_force = 0; m_trig_addr = 0;
            m_trig_idx = -1; m_ns = 0; m_samp.delete();
        end else begin
            se     = filt_done && !m_fd_q;
            m_fd_q = filt_done;
            if (arm) begin
                m_armed = 1; m_pret = int'(pretrig_len); m_ns = 0;
                m_trig_idx = -1; m_force = 0; m_samp.delete();
            end else if (m_armed && !m_done_before) begin
                waiting = (m_ns >= m_pret) && (m_trig_idx < 0);
                hit = 0;
                if (se) begin
                    k = m_ns;
                    m_samp.push_back(filt_result);
                    m_ns++;
                    if (waiting && (m_force || (k >= 1 && crosses(m_samp[k-1], filt_result)))) begin
                        m_trig_idx = k; m_trig_addr = k % DEPTH; m_force = 0; hit = 1;
                    end
                end
                if (waiting && force_trig && !hit) m_force = 1;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_done", capt_done, 0);
            check("rst_trig_addr", trig_addr, 0);
            check("rst_rd_data", rd_data, 0);
        end else begin
            check("busy", busy, m_armed && !m_done());
            check("capt_done", capt_done, m_done());
            check("trig_addr", trig_addr, m_trig_addr);
            if (m_done_before && m_done())
                check("rd_data", rd_data, m_samp[m_trig_idx - m_pret + m_rd_at_edge]);
        end
    end

    task automatic send(input logic [DW-1:0] v, input int w = 2, input int g = 0);
        @(negedge clk);
        filt_result = v;
        filt_done   = 1'b1;
        repeat (w) @(negedge clk);
        filt_done = 1'b0;
        repeat (g) @(negedge clk);
    endtask

    task automatic do_arm(input int pret, input int lvl, input bit edg);
        @(negedge clk);
        arm = 1'b1; pretrig_len = AW'(pret); trig_level = DW'(lvl); trig_edge = edg;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic pulse_force();
        @(negedge clk); force_trig = 1'b1;
        @(negedge clk); force_trig = 1'b0;
    endtask

    task automatic read_chk(input string name, input int a, input logic [DW-1:0] exp);
        @(negedge clk); rd_addr = AW'(a);
        @(posedge clk); #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        // 1. reset, then filt_done toggling without arm
        repeat (3) begin @(negedge clk); filt_done = ~filt_done; end
        @(negedge clk); rst = 1'b0; filt_done = 1'b0;
        repeat (4) send(16'h55);
        check("t1_busy", busy, 0);
        check("t1_done", capt_done, 0);
        check("t1_trig_addr", trig_addr, 0);

        // 2. rising trigger on a ramp
        do_arm(4, 1000, 1'b0);
        for (int k = 0; k <= 25; k++) send(DW'(k * 100));
        check("t2_done", capt_done, 1);
        check("t2_trig_addr", trig_addr, 10);
        read_chk("t2_rd0", 0, 600);
        read_chk("t2_rd4", 4, 1000);
        read_chk("t2_rd15", 15, 2100);

        // 3. falling trigger
        do_arm(2, 500, 1'b1);
        repeat (8) send(800);
        repeat (20) send(400);
        check("t3_trig_addr", trig_addr, 8);
        read_chk("t3_rd0", 0, 800);
        read_chk("t3_rd1", 1, 800);
        for (int a = 2; a < 16; a++) read_chk("t3_rd", a, 400);

        // 4. forced trigger on a flat signal
        do_arm(3, 16'h2000, 1'b0);
        repeat (6) send(16'h1234);
        pulse_force();
        send(16'h1234);
        check("t4_trig_addr", trig_addr, 6);
        repeat (11) send(16'h1234);
        check("t4_not_done", capt_done, 0);
        send(16'h1234);
        check("t4_done", capt_done, 1);
        for (int a = 0; a < 16; a++) read_chk("t4_rd", a, 16'h1234);

        // 5. long pulse, then arm coincident with a sample mid-POST
        do_arm(2, 100, 1'b0);
        send(50, 3);
        send(50); send(50); send(150); send(60); send(70);
        @(negedge clk);
        arm = 1'b1; filt_done = 1'b1; filt_result = 999; pretrig_len = 2;
        @(negedge clk); arm = 1'b0;
        @(negedge clk); filt_done = 1'b0;
        check("t5_busy", busy, 1);
        check("t5_done", capt_done, 0);
        send(10); send(20); send(300);
        repeat (13) send(400);
        check("t5_redone", capt_done, 1);
        read_chk("t5_rd0", 0, 10);
        read_chk("t5_rd2", 2, 300);

        // 6a. pretrig 15: done on the trigger sample itself
        do_arm(15, 1000, 1'b0);
        for (int k = 0; k < 16; k++) send(DW'(k * 10));
        check("t6a_not_done", capt_done, 0);
        send(5000);
        check("t6a_done", capt_done, 1);
        read_chk("t6a_rd15", 15, 5000);
        // 6b. pretrig 0
        do_arm(0, 1000, 1'b0);
        send(10); send(20); send(30); send(2000);
        for (int k = 4; k < 19; k++) send(DW'(3000 + k));
        check("t6b_done", capt_done, 1);
        read_chk("t6b_rd0", 0, 2000);
        // 6c. asynchronous reset during POST
        do_arm(1, 100, 1'b0);
        send(0); send(500); send(600);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        check("t6c_busy", busy, 0);
        check("t6c_done", capt_done, 0);
        check("t6c_trig_addr", trig_addr, 0);
        check("t6c_rd_data", rd_data, 0);
        @(negedge clk); rst = 1'b0;

        // random captures, occasionally re-armed mid-flight
        for (int it = 0; it < 30; it++) begin
            do_arm($urandom_range(0, 15), $urandom_range(100, 900), 1'($urandom_range(0, 1)));
            n = 0;
            while (!m_done() && n < 150) begin
                if ($urandom_range(0, 19) == 0 || n >= 100) pulse_force();
                if (n < 90 && $urandom_range(0, 59) == 0)
                    do_arm($urandom_range(0, 15), $urandom_range(100, 900),
                           1'($urandom_range(0, 1)));
                rd_addr = AW'($urandom_range(0, 15));
                send(DW'($urandom_range(0, 1000)), $urandom_range(1, 3), $urandom_range(0, 2));
                n++;
            end
            check("rand_capt_done", capt_done, 1);
            repeat (8) begin @(negedge clk); rd_addr = AW'($urandom_range(0, 15)); end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
